// File: rtl/redmule_z_buffer_sched.sv
// Tile-level sequencer for the RedMulE Z/Y accumulation buffer: walks each tile through
// Y preload, Y push, Z row collection and Z drain, and gates the buffer controls accordingly.
module redmule_z_buffer_sched #(
    parameter int unsigned W   = 12,
    parameter int unsigned D   = 18,
    parameter int unsigned TCW = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [TCW-1:0]       cfg_n_tiles_i,
    input  logic                 cfg_y_bias_i,
    input  logic [$clog2(W):0]   cfg_y_width_i,
    input  logic [$clog2(D):0]   cfg_y_height_i,
    input  logic [$clog2(W):0]   cfg_z_width_i,
    input  logic [$clog2(D):0]   cfg_z_height_i,
    input  logic                 y_stream_valid_i,
    output logic                 y_stream_ready_o,
    input  logic                 z_stream_ready_i,
    output logic                 z_stream_valid_o,
    input  logic                 engine_push_req_i,
    input  logic                 engine_fill_i,
    input  logic                 flg_y_ready_i,
    input  logic                 flg_loaded_i,
    input  logic                 flg_y_pushed_i,
    input  logic                 flg_z_valid_i,
    input  logic                 flg_empty_i,
    output logic                 ctrl_fill_o,
    output logic                 ctrl_y_valid_o,
    output logic                 ctrl_y_push_enable_o,
    output logic                 ctrl_ready_o,
    output logic                 ctrl_first_load_o,
    output logic [$clog2(W):0]   ctrl_y_width_o,
    output logic [$clog2(D):0]   ctrl_y_height_o,
    output logic [$clog2(W):0]   ctrl_z_width_o,
    output logic [$clog2(D):0]   ctrl_z_height_o,
    output logic                 z_buf_clear_o,
    output logic [TCW-1:0]       tile_cnt_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam int unsigned WW = $clog2(W) + 1;
    localparam int unsigned HW = $clog2(D) + 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_PUSH    = 3'd2;
    localparam logic [2:0] ST_COMPUTE = 3'd3;
    localparam logic [2:0] ST_STORE   = 3'd4;

    logic [2:0]     state;
    logic [TCW-1:0] tile_cnt;
    logic [TCW-1:0] tile_next;
    logic [HW-1:0]  fill_cnt;
    logic           first_load;
    logic           err_q;
    logic           done_q;
    logic [TCW-1:0] n_tiles_q;
    logic           y_bias_q;
    logic [WW-1:0]  y_width_q;
    logic [HW-1:0]  y_height_q;
    logic [WW-1:0]  z_width_q;
    logic [HW-1:0]  z_height_q;
    logic           run;
    logic           start_ok;

    assign run       = !rst_i;
    assign start_ok  = (state == ST_IDLE) && start_i;
    assign tile_next = tile_cnt + TCW'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state      <= ST_IDLE;
            tile_cnt   <= '0;
            fill_cnt   <= '0;
            first_load <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            n_tiles_q  <= '0;
            y_bias_q   <= 1'b0;
            y_width_q  <= '0;
            y_height_q <= '0;
            z_width_q  <= '0;
            z_height_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        n_tiles_q  <= cfg_n_tiles_i;
                        y_bias_q   <= cfg_y_bias_i;
                        y_width_q  <= cfg_y_width_i;
                        y_height_q <= cfg_y_height_i;
                        z_width_q  <= cfg_z_width_i;
                        z_height_q <= cfg_z_height_i;
                        tile_cnt   <= '0;
                        fill_cnt   <= '0;
                        err_q      <= 1'b0;
                        if (cfg_n_tiles_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            first_load <= 1'b1;
                            state      <= cfg_y_bias_i ? ST_LOAD : ST_COMPUTE;
                        end
                    end
                end
                ST_LOAD: begin
                    if (flg_loaded_i) state <= ST_PUSH;
                end
                ST_PUSH: begin
                    if (flg_y_pushed_i) begin
                        state      <= ST_COMPUTE;
                        first_load <= 1'b0;
                    end
                end
                ST_COMPUTE: begin
                    if (engine_fill_i) begin
                        if (fill_cnt == z_height_q - HW'(1)) begin
                            fill_cnt   <= '0;
                            first_load <= 1'b0;
                            state      <= ST_STORE;
                        end else begin
                            fill_cnt <= fill_cnt + HW'(1);
                        end
                    end
                end
                ST_STORE: begin
                    if (flg_empty_i) begin
                        tile_cnt <= tile_next;
                        if (tile_next == n_tiles_q) begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                        end else begin
                            state <= y_bias_q ? ST_LOAD : ST_COMPUTE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // A stray fill is flagged after the start handling so it wins over the start-time clear.
            if (engine_fill_i && (state != ST_COMPUTE)) err_q <= 1'b1;
        end
    end

    always_comb begin
        y_stream_ready_o     = 1'b0;
        z_stream_valid_o     = 1'b0;
        ctrl_fill_o          = 1'b0;
        ctrl_y_valid_o       = 1'b0;
        ctrl_y_push_enable_o = 1'b0;
        ctrl_ready_o         = 1'b0;
        ctrl_first_load_o    = 1'b0;
        if (run) begin
            case (state)
                ST_LOAD: begin
                    ctrl_y_valid_o    = y_stream_valid_i;
                    y_stream_ready_o  = flg_y_ready_i;
                    ctrl_first_load_o = first_load;
                end
                ST_PUSH: begin
                    ctrl_y_push_enable_o = engine_push_req_i;
                    ctrl_first_load_o    = first_load;
                end
                ST_COMPUTE: ctrl_fill_o = engine_fill_i;
                ST_STORE: begin
                    ctrl_ready_o     = z_stream_ready_i;
                    z_stream_valid_o = flg_z_valid_i;
                end
                default: ;
            endcase
        end
    end

    assign z_buf_clear_o   = clear_i | (run & start_ok);
    assign busy_o          = run & (state != ST_IDLE);
    assign done_o          = run & done_q;
    assign err_o           = run & err_q;
    assign tile_cnt_o      = run ? tile_cnt : '0;
    assign ctrl_y_width_o  = busy_o ? y_width_q  : '0;
    assign ctrl_y_height_o = busy_o ? y_height_q : '0;
    assign ctrl_z_width_o  = busy_o ? z_width_q  : '0;
    assign ctrl_z_height_o = busy_o ? z_height_q : '0;

endmodule

// File: tb/tb_redmule_z_buffer_sched.sv
// Self-checking bench for redmule_z_buffer_sched: a phase-level model checks every output on
// every negedge, while directed scenarios pin beat counts and completion behaviour with literals.
module tb_redmule_z_buffer_sched;

    localparam int W   = 12;
    localparam int D   = 18;
    localparam int TCW = 16;
    localparam int WW  = $clog2(W) + 1;
    localparam int HW  = $clog2(D) + 1;

    localparam int P_IDLE    = 0;
    localparam int P_LOAD    = 1;
    localparam int P_PUSH    = 2;
    localparam int P_COMPUTE = 3;
    localparam int P_STORE   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_i, clear_i, start_i, cfg_y_bias_i;
    logic [TCW-1:0] cfg_n_tiles_i;
    logic [WW-1:0]  cfg_y_width_i, cfg_z_width_i;
    logic [HW-1:0]  cfg_y_height_i, cfg_z_height_i;
    logic           y_stream_valid_i, z_stream_ready_i, engine_push_req_i, engine_fill_i;
    logic           flg_y_ready_i, flg_loaded_i, flg_y_pushed_i, flg_z_valid_i, flg_empty_i;
    logic           y_stream_ready_o, z_stream_valid_o;
    logic           ctrl_fill_o, ctrl_y_valid_o, ctrl_y_push_enable_o, ctrl_ready_o, ctrl_first_load_o;
    logic [WW-1:0]  ctrl_y_width_o, ctrl_z_width_o;
    logic [HW-1:0]  ctrl_y_height_o, ctrl_z_height_o;
    logic           z_buf_clear_o, busy_o, done_o, err_o;
    logic [TCW-1:0] tile_cnt_o;

    redmule_z_buffer_sched #(.W(W), .D(D), .TCW(TCW)) dut (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
        .cfg_n_tiles_i(cfg_n_tiles_i), .cfg_y_bias_i(cfg_y_bias_i),
        .cfg_y_width_i(cfg_y_width_i), .cfg_y_height_i(cfg_y_height_i),
        .cfg_z_width_i(cfg_z_width_i), .cfg_z_height_i(cfg_z_height_i),
        .y_stream_valid_i(y_stream_valid_i), .y_stream_ready_o(y_stream_ready_o),
        .z_stream_ready_i(z_stream_ready_i), .z_stream_valid_o(z_stream_valid_o),
        .engine_push_req_i(engine_push_req_i), .engine_fill_i(engine_fill_i),
        .flg_y_ready_i(flg_y_ready_i), .flg_loaded_i(flg_loaded_i), .flg_y_pushed_i(flg_y_pushed_i),
        .flg_z_valid_i(flg_z_valid_i), .flg_empty_i(flg_empty_i),
        .ctrl_fill_o(ctrl_fill_o), .ctrl_y_valid_o(ctrl_y_valid_o),
        .ctrl_y_push_enable_o(ctrl_y_push_enable_o), .ctrl_ready_o(ctrl_ready_o),
        .ctrl_first_load_o(ctrl_first_load_o),
        .ctrl_y_width_o(ctrl_y_width_o), .ctrl_y_height_o(ctrl_y_height_o),
        .ctrl_z_width_o(ctrl_z_width_o), .ctrl_z_height_o(ctrl_z_height_o),
        .z_buf_clear_o(z_buf_clear_o), .tile_cnt_o(tile_cnt_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Beat counters fed by the compare process, read as deltas by the scenarios.
    int cnt_yvalid = 0, cnt_push = 0, cnt_first = 0, cnt_fill = 0, cnt_ready = 0, cnt_done = 0;

    // Model state: which phase the tile is in, how many tiles and rows are complete.
    int m_phase = P_IDLE, m_tiles = 0, m_rows = 0, m_n = 0, m_bias = 0;
    int m_yw = 0, m_yh = 0, m_zw = 0, m_zh = 0;
    bit m_err = 1'b0, m_done = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare the DUT against the model every cycle, then advance the model by the inputs
    // that the next rising edge will sample.
    always @(negedge clk) begin : compare
        bit e_busy, e_zclr, e_yrdy, e_yvalid, e_push, e_first, e_fill, e_ready, e_zvalid;
        int e_tiles, e_yw, e_yh, e_zw, e_zh, ph;
        if (rst_i) begin
            {e_busy, e_yrdy, e_yvalid, e_push, e_first, e_fill, e_ready, e_zvalid} = '0;
            e_zclr = clear_i;
            e_tiles = 0; e_yw = 0; e_yh = 0; e_zw = 0; e_zh = 0;
        end else begin
            e_busy   = (m_phase != P_IDLE);
            e_zclr   = clear_i || (m_phase == P_IDLE && start_i);
            e_yrdy   = (m_phase == P_LOAD) && flg_y_ready_i;
            e_yvalid = (m_phase == P_LOAD) && y_stream_valid_i;
            e_push   = (m_phase == P_PUSH) && engine_push_req_i;
            e_first  = (m_phase == P_LOAD || m_phase == P_PUSH) && (m_tiles == 0);
            e_fill   = (m_phase == P_COMPUTE) && engine_fill_i;
            e_ready  = (m_phase == P_STORE) && z_stream_ready_i;
            e_zvalid = (m_phase == P_STORE) && flg_z_valid_i;
            e_tiles  = m_tiles;
            e_yw = e_busy ? m_yw : 0;
            e_yh = e_busy ? m_yh : 0;
            e_zw = e_busy ? m_zw : 0;
            e_zh = e_busy ? m_zh : 0;
        end
        checkOutput("busy", 32'(busy_o), 32'(e_busy));
        checkOutput("done", 32'(done_o), 32'(m_done && !rst_i));
        checkOutput("err", 32'(err_o), 32'(m_err && !rst_i));
        checkOutput("tile_cnt", 32'(tile_cnt_o), 32'(e_tiles));
        checkOutput("z_buf_clear", 32'(z_buf_clear_o), 32'(e_zclr));
        checkOutput("y_stream_ready", 32'(y_stream_ready_o), 32'(e_yrdy));
        checkOutput("ctrl_y_valid", 32'(ctrl_y_valid_o), 32'(e_yvalid));
        checkOutput("ctrl_y_push_enable", 32'(ctrl_y_push_enable_o), 32'(e_push));
        checkOutput("ctrl_first_load", 32'(ctrl_first_load_o), 32'(e_first));
        checkOutput("ctrl_fill", 32'(ctrl_fill_o), 32'(e_fill));
        checkOutput("ctrl_ready", 32'(ctrl_ready_o), 32'(e_ready));
        checkOutput("z_stream_valid", 32'(z_stream_valid_o), 32'(e_zvalid));
        checkOutput("ctrl_y_width", 32'(ctrl_y_width_o), 32'(e_yw));
        checkOutput("ctrl_y_height", 32'(ctrl_y_height_o), 32'(e_yh));
        checkOutput("ctrl_z_width", 32'(ctrl_z_width_o), 32'(e_zw));
        checkOutput("ctrl_z_height", 32'(ctrl_z_height_o), 32'(e_zh));

        if (ctrl_y_valid_o)       cnt_yvalid++;
        if (ctrl_y_push_enable_o) cnt_push++;
        if (ctrl_first_load_o)    cnt_first++;
        if (ctrl_fill_o)          cnt_fill++;
        if (ctrl_ready_o)         cnt_ready++;
        if (done_o)               cnt_done++;

        if (rst_i || clear_i) begin
            m_phase = P_IDLE; m_tiles = 0; m_rows = 0; m_n = 0; m_bias = 0;
            m_yw = 0; m_yh = 0; m_zw = 0; m_zh = 0; m_err = 1'b0; m_done = 1'b0;
        end else begin
            ph = m_phase;
            m_done = 1'b0;
            if (ph == P_IDLE && start_i) begin
                m_n = int'(cfg_n_tiles_i); m_bias = int'(cfg_y_bias_i);
                m_yw = int'(cfg_y_width_i); m_yh = int'(cfg_y_height_i);
                m_zw = int'(cfg_z_width_i); m_zh = int'(cfg_z_height_i);
                m_tiles = 0; m_rows = 0; m_err = 1'b0;
                if (m_n == 0) m_done = 1'b1;
                else          m_phase = m_bias ? P_LOAD : P_COMPUTE;
            end else if (ph == P_LOAD && flg_loaded_i) begin
                m_phase = P_PUSH;
            end else if (ph == P_PUSH && flg_y_pushed_i) begin
                m_phase = P_COMPUTE;
            end else if (ph == P_COMPUTE && engine_fill_i) begin
                m_rows++;
                if (m_rows == m_zh) begin
                    m_rows = 0;
                    m_phase = P_STORE;
                end
            end else if (ph == P_STORE && flg_empty_i) begin
                m_tiles++;
                if (m_tiles == m_n) begin
                    m_phase = P_IDLE;
                    m_done = 1'b1;
                end else begin
                    m_phase = m_bias ? P_LOAD : P_COMPUTE;
                end
            end
            if (engine_fill_i && ph != P_COMPUTE) m_err = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int n, input int bias, input int yw, input int yh, input int zw, input int zh);
        cfg_n_tiles_i  = TCW'(n);
        cfg_y_bias_i   = bias[0];
        cfg_y_width_i  = WW'(yw);
        cfg_y_height_i = HW'(yh);
        cfg_z_width_i  = WW'(zw);
        cfg_z_height_i = HW'(zh);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    // Drives one whole tile: Y beats, Y rows pushed (with a stray empty flag), Z rows, optional
    // Z backpressure, Z beats, then the empty flag that closes the tile.
    task automatic applyStimulus(input int bias, input int yw, input int yh, input int zh,
                                 input int zw, input int stall, input bit fill_in_push);
        int done_before;
        if (bias != 0) begin
            y_stream_valid_i = 1'b1; flg_y_ready_i = 1'b1;
            repeat (yw) step();
            y_stream_valid_i = 1'b0; flg_y_ready_i = 1'b0; flg_loaded_i = 1'b1;
            step();
            flg_loaded_i = 1'b0;
            engine_push_req_i = 1'b1; flg_empty_i = 1'b1; engine_fill_i = fill_in_push;
            repeat (yh) step();
            engine_push_req_i = 1'b0; flg_empty_i = 1'b0; engine_fill_i = 1'b0; flg_y_pushed_i = 1'b1;
            step();
            flg_y_pushed_i = 1'b0;
        end
        engine_fill_i = 1'b1;
        repeat (zh) step();
        engine_fill_i = 1'b0;
        flg_z_valid_i = 1'b1;
        done_before = cnt_done;
        repeat (stall) step();
        if (stall > 0) begin
            checkOutput("stall_busy_held", 32'(busy_o), 32'd1);
            checkOutput("stall_no_done", 32'(cnt_done - done_before), 32'd0);
        end
        z_stream_ready_i = 1'b1;
        repeat (zw) step();
        z_stream_ready_i = 1'b0; flg_z_valid_i = 1'b0; flg_empty_i = 1'b1;
        step();
        flg_empty_i = 1'b0;
    endtask

    initial begin : watchdog
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : stimulus
        int s_y, s_p, s_f, s_fill, s_rdy, s_done;
        rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0;
        cfg_n_tiles_i = '0; cfg_y_bias_i = 1'b0;
        cfg_y_width_i = '0; cfg_y_height_i = '0; cfg_z_width_i = '0; cfg_z_height_i = '0;
        y_stream_valid_i = 1'b0; z_stream_ready_i = 1'b0; engine_push_req_i = 1'b0; engine_fill_i = 1'b0;
        flg_y_ready_i = 1'b0; flg_loaded_i = 1'b0; flg_y_pushed_i = 1'b0; flg_z_valid_i = 1'b0; flg_empty_i = 1'b0;
        step(); step();
        rst_i = 1'b0;
        checkOutput("reset_busy", 32'(busy_o), 32'd0);
        checkOutput("reset_tile_cnt", 32'(tile_cnt_o), 32'd0);
        checkOutput("reset_done", 32'(done_o), 32'd0);
        checkOutput("reset_err", 32'(err_o), 32'd0);

        $display("[TB] bias off, one tile of 4 rows x 3 beats");
        start_job(1, 0, 1, 1, 3, 4);
        checkOutput("s1_busy_after_start", 32'(busy_o), 32'd1);
        s_fill = cnt_fill; s_rdy = cnt_ready; s_done = cnt_done;
        applyStimulus(0, 0, 0, 4, 3, 0, 1'b0);
        checkOutput("s1_fill_rows", 32'(cnt_fill - s_fill), 32'd4);
        checkOutput("s1_ready_beats", 32'(cnt_ready - s_rdy), 32'd3);
        checkOutput("s1_done", 32'(done_o), 32'd1);
        checkOutput("s1_busy_end", 32'(busy_o), 32'd0);
        checkOutput("s1_tile_cnt", 32'(tile_cnt_o), 32'd1);
        step();
        checkOutput("s1_done_pulses", 32'(cnt_done - s_done), 32'd1);

        $display("[TB] bias on, two tiles, Y 3 wide x 4 high");
        start_job(2, 1, 3, 4, 1, 2);
        s_y = cnt_yvalid; s_p = cnt_push; s_f = cnt_first;
        applyStimulus(1, 3, 4, 2, 1, 0, 1'b0);
        checkOutput("s2_t0_y_valid", 32'(cnt_yvalid - s_y), 32'd3);
        checkOutput("s2_t0_push", 32'(cnt_push - s_p), 32'd4);
        checkOutput("s2_t0_first_load", 32'(cnt_first - s_f), 32'd9);
        checkOutput("s2_t0_tile_cnt", 32'(tile_cnt_o), 32'd1);
        s_y = cnt_yvalid; s_p = cnt_push; s_f = cnt_first;
        applyStimulus(1, 3, 4, 2, 1, 0, 1'b0);
        checkOutput("s2_t1_y_valid", 32'(cnt_yvalid - s_y), 32'd3);
        checkOutput("s2_t1_push", 32'(cnt_push - s_p), 32'd4);
        checkOutput("s2_t1_first_load", 32'(cnt_first - s_f), 32'd0);
        checkOutput("s2_done", 32'(done_o), 32'd1);
        checkOutput("s2_tile_cnt", 32'(tile_cnt_o), 32'd2);
        step();

        $display("[TB] single-row tile with 5 cycles of Z backpressure");
        start_job(1, 0, 1, 1, 2, 1);
        s_rdy = cnt_ready;
        applyStimulus(0, 0, 0, 1, 2, 5, 1'b0);
        checkOutput("s3_ready_beats", 32'(cnt_ready - s_rdy), 32'd2);
        checkOutput("s3_done", 32'(done_o), 32'd1);
        step();

        $display("[TB] stray engine fill during PUSH");
        start_job(1, 1, 2, 2, 1, 1);
        s_fill = cnt_fill;
        applyStimulus(1, 2, 2, 1, 1, 0, 1'b1);
        checkOutput("s4_fill_forwarded", 32'(cnt_fill - s_fill), 32'd1);
        checkOutput("s4_err_set", 32'(err_o), 32'd1);
        step(); step();
        checkOutput("s4_err_sticky", 32'(err_o), 32'd1);

        $display("[TB] empty job");
        start_job(0, 0, 1, 1, 1, 1);
        checkOutput("s6_done", 32'(done_o), 32'd1);
        checkOutput("s6_busy", 32'(busy_o), 32'd0);
        checkOutput("s6_err_cleared", 32'(err_o), 32'd0);
        step();
        checkOutput("s6_done_once", 32'(done_o), 32'd0);

        $display("[TB] start while busy is ignored");
        start_job(1, 0, 1, 1, 1, 3);
        cfg_z_height_i = HW'(1); cfg_n_tiles_i = TCW'(5); start_i = 1'b1;
        step();
        start_i = 1'b0;
        checkOutput("s7_z_height_kept", 32'(ctrl_z_height_o), 32'd3);
        applyStimulus(0, 0, 0, 3, 1, 0, 1'b0);
        checkOutput("s7_done", 32'(done_o), 32'd1);
        checkOutput("s7_tile_cnt", 32'(tile_cnt_o), 32'd1);
        step();

        $display("[TB] clear in STORE of tile 1 of 3");
        start_job(3, 0, 1, 1, 1, 2);
        s_done = cnt_done;
        applyStimulus(0, 0, 0, 2, 1, 0, 1'b0);
        checkOutput("s5_tile_cnt_mid", 32'(tile_cnt_o), 32'd1);
        engine_fill_i = 1'b1;
        repeat (2) step();
        engine_fill_i = 1'b0; flg_z_valid_i = 1'b1; z_stream_ready_i = 1'b1; clear_i = 1'b1;
        #1;
        checkOutput("s5_z_buf_clear", 32'(z_buf_clear_o), 32'd1);
        step();
        clear_i = 1'b0;
        #1;
        checkOutput("s5_busy", 32'(busy_o), 32'd0);
        checkOutput("s5_tile_cnt", 32'(tile_cnt_o), 32'd0);
        checkOutput("s5_ctrl_ready_idle", 32'(ctrl_ready_o), 32'd0);
        flg_z_valid_i = 1'b0; z_stream_ready_i = 1'b0;
        step(); step();
        checkOutput("s5_no_done", 32'(cnt_done - s_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/redmule_z_buffer_sched.md
Name: redmule_z_buffer_sched

Overview:
- Tile-level sequencer for the RedMulE Z/Y accumulation buffer.
- Generates the buffer control bundle (fill, y_valid, y_push_enable, ready, first_load, dims) and the buffer clear from the engine and streamer handshakes.
- Consumes the buffer flags (y_ready, loaded, y_pushed, z_valid, empty).
- Per tile, in order: optional Y preload, Y push into the array, Z row collection, Z drain to the streamer. Repeats for N tiles.

Parameters:
- W, 12 (ARRAY_WIDTH): max Y width / Z columns.
- D, 18: max Z height (DW/BITW).
- TCW, 16: tile counter width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- clear_i  in  1  synchronous soft clear
- start_i  in  1  start job (accepted only in IDLE)
- cfg_n_tiles_i  in  TCW  tiles in job
- cfg_y_bias_i  in  1  1: preload/push Y per tile
- cfg_y_width_i  in  $clog2(W)+1  Y width, 1..W
- cfg_y_height_i  in  $clog2(D)+1  Y height, 1..D
- cfg_z_width_i  in  $clog2(W)+1  Z store beats, 1..W
- cfg_z_height_i  in  $clog2(D)+1  Z rows, 1..D
- y_stream_valid_i  in  1  Y streamer data valid
- y_stream_ready_o  out  1  Y beat accepted
- z_stream_ready_i  in  1  Z streamer ready
- z_stream_valid_o  out  1  Z beat valid
- engine_push_req_i  in  1  engine accepts a Y row this cycle
- engine_fill_i  in  1  engine delivers a Z row this cycle
- flg_y_ready_i / flg_loaded_i / flg_y_pushed_i / flg_z_valid_i / flg_empty_i  in  1 each  buffer flags
- ctrl_fill_o / ctrl_y_valid_o / ctrl_y_push_enable_o / ctrl_ready_o / ctrl_first_load_o  out  1 each  buffer controls
- ctrl_y_width_o / ctrl_y_height_o / ctrl_z_width_o / ctrl_z_height_o  out  cfg widths  latched dims
- z_buf_clear_o  out  1  buffer clear
- tile_cnt_o  out  TCW  completed tiles
- busy_o  out  1  state != IDLE
- done_o  out  1  1-cycle job completion pulse
- err_o  out  1  sticky protocol error

Behaviour:
- Reset / clear:
  - rst_i or clear_i: state=IDLE; tile_cnt, fill_cnt, first_load, err, done and latched cfg all 0.
  - Every output is 0 under reset, except that z_buf_clear_o = clear_i, combinationally.
  - clear_i mid-job aborts with no done_o.
- Timing: state and counters are registered. All ctrl_*, stream and handshake outputs are combinational from state and inputs (0-cycle gating).
- IDLE:
  - On start_i, latch cfg and assert z_buf_clear_o in the same cycle.
  - If n_tiles==0: done_o pulses the next cycle and the state stays IDLE.
  - Otherwise: first_load=1; next state is LOAD if y_bias, else COMPUTE.
  - start_i outside IDLE is ignored.
- LOAD:
  - ctrl_y_valid_o = y_stream_valid_i.
  - y_stream_ready_o = flg_y_ready_i.
  - On flg_loaded_i -> PUSH.
- PUSH:
  - ctrl_y_push_enable_o = engine_push_req_i.
  - On flg_y_pushed_i -> COMPUTE and first_load<=0.
  - flg_empty_i seen here is ignored.
- COMPUTE:
  - ctrl_fill_o = engine_fill_i; fill_cnt increments on each fill.
  - Fill with fill_cnt==z_height-1: fill_cnt<=0 and -> STORE (covers z_height=1).
- STORE:
  - ctrl_ready_o = z_stream_ready_i.
  - z_stream_valid_o = flg_z_valid_i.
  - On flg_empty_i: tile_cnt++.
  - If the incremented tile_cnt == n_tiles: -> IDLE with done_o pulse (same edge).
  - Otherwise: -> LOAD or COMPUTE per y_bias.
- ctrl_first_load_o = first_load, during LOAD/PUSH of tile 0 only.
- engine_fill_i outside COMPUTE:
  - not forwarded (ctrl_fill_o=0);
  - sets err_o, which stays set until the next accepted start_i.
- Unused gating inputs in a state are ignored; all ctrl outputs are 0 in IDLE.
- tile_cnt saturates nowhere; it is bounded by n_tiles.

Test Plan:
- Bias off, n_tiles=1, z_height=4, z_width=3, buffer model attached:
  - start -> COMPUTE next cycle;
  - 4 fills -> STORE;
  - 3 ready beats, flg_empty -> done_o one pulse, busy_o 0, tile_cnt_o=1.
- Bias on, n_tiles=2, y_width=3, y_height=4:
  - LOAD forwards exactly 3 y_valid beats and PUSH 4 push_enables;
  - ctrl_first_load_o=1 in tile 0 only;
  - done after tile_cnt_o=2.
- STORE backpressure, z_stream_ready_i=0 for 5 cycles:
  - ctrl_ready_o=0 throughout;
  - state held, no done_o;
  - resumes on ready.
- engine_fill_i=1 during PUSH: ctrl_fill_o=0; err_o=1 and stays until next start.
- clear_i in STORE of tile 1 of 3:
  - z_buf_clear_o=1 that cycle;
  - next cycle IDLE, tile_cnt_o=0, outputs 0, no done_o.
- start_i with n_tiles=0:
  - done_o pulse next cycle, busy_o never 1.
  - start_i while busy: ignored, cfg unchanged.
